t48_io_expander: RTL

- Bus responder for the T48 PROG strobe: a cycle-based model of an 8243-style I/O expander.
- Sits on the expander bus opposite the T48 clock/strobe controller, which acts as the initiator.
- Decodes the opcode and port from P2[3:0] on PROG assertion, then completes the transfer on PROG release.
- Provides four 4-bit ports (P4..P7) with read, write, OR and AND operations.

---
 rtl/t48_io_expander_pkg.sv | 36 +++
 rtl/t48_io_expander_if.sv | 25 ++
 rtl/t48_io_expander_port.sv | 47 ++++
 rtl/t48_io_expander.sv | 113 +++++++++++
 4 files changed

// File: rtl/t48_io_expander_pkg.sv
// Shared types for the T48 I/O expander: opcodes, FSM states, port geometry
// and the 4-bit latch update rule used by every port.
package t48_io_exp_pack;

  localparam int PORT_W  = 4;
  localparam int N_PORTS = 4;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_OR    = 2'b10,
    OP_AND   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_READ   = 2'b01,
    ST_MODIFY = 2'b10
  } state_e;

  // Modify operations act on the output latch, never on the pin level.
  function automatic logic [PORT_W-1:0] apply_op(input op_e op,
                                                 input logic [PORT_W-1:0] latch,
                                                 input logic [PORT_W-1:0] data);
    logic [PORT_W-1:0] res;
    res = latch;
    case (op)
      OP_WRITE: res = data;
      OP_OR:    res = latch | data;
      OP_AND:   res = latch & data;
      default:  res = latch;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/t48_io_expander_if.sv
// Expander bus between the T48 (master) and the 8243-style expander (slave),
// plus the four 4-bit port pins/latches/enables of P7..P4.
interface t48_io_expander_if;
  import t48_io_exp_pack::*;

  logic                        cs_n;
  logic                        prog_n;
  logic [PORT_W-1:0]           p2_in;
  logic [PORT_W-1:0]           p2_out;
  logic                        p2_en;
  logic [N_PORTS*PORT_W-1:0]   port_in;
  logic [N_PORTS*PORT_W-1:0]   port_out;
  logic [N_PORTS-1:0]          port_en;

  modport master (
    output cs_n, prog_n, p2_in, port_in,
    input  p2_out, p2_en, port_out, port_en
  );

  modport slave (
    input  cs_n, prog_n, p2_in, port_in,
    output p2_out, p2_en, port_out, port_en
  );

endinterface

// File: rtl/t48_io_expander_port.sv
// One expander port: its output latch and output enable.
module t48_io_exp_port
  import t48_io_exp_pack::*;
#(
  parameter logic [PORT_W-1:0] RESET_VAL = '0
) (
  input  logic              clk_i,
  input  logic              res_i,
  input  logic              sel_i,
  input  op_e               op_i,
  input  logic              apply_i,
  input  logic              read_i,
  input  logic [PORT_W-1:0] data_i,
  output logic [PORT_W-1:0] latch_o,
  output logic              en_o
);

  logic [PORT_W-1:0] latch_q, latch_d;
  logic              en_q, en_d;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    latch_d = latch_q;
    en_d    = en_q;
    if (sel_i && read_i) begin
      en_d = 1'b0;
    end else if (sel_i && apply_i) begin
      latch_d = apply_op(op_i, latch_q, data_i);
      en_d    = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      latch_q <= RESET_VAL;
      en_q    <= 1'b0;
    end else begin
      latch_q <= latch_d;
      en_q    <= en_d;
    end
  end

  assign latch_o = latch_q;
  assign en_o    = en_q;

endmodule

// File: rtl/t48_io_expander.sv
// 8243-style I/O expander: PROG edge detect, transfer FSM and P2 read mux,
// with four port latches decoded from P2 on PROG fall, completed on PROG rise.
module t48_io_expander
  import t48_io_exp_pack::*;
#(
  parameter logic [PORT_W-1:0] PORT_RESET_VAL = 4'h0
) (
  input  logic clk_i,
  input  logic res_i,
  input  logic en_clk_i,
  t48_io_expander_if.slave bus
);

  logic              prog_q;
  state_e            state_q, state_d;
  op_e               op_q, op_d;
  logic [1:0]        sel_q, sel_d;
  logic [PORT_W-1:0] p2_q, p2_d;
  logic              p2_en_q, p2_en_d;
  logic              apply_s, read_s;
  logic              fall, rise;

  logic [N_PORTS-1:0][PORT_W-1:0] latch_w;
  logic [N_PORTS-1:0]             en_w;

  assign fall = prog_q & ~bus.prog_n;
  assign rise = ~prog_q & bus.prog_n;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    sel_d   = sel_q;
    p2_d    = p2_q;
    p2_en_d = p2_en_q;
    apply_s = 1'b0;
    read_s  = 1'b0;
    if (en_clk_i) begin
      case (state_q)
        ST_IDLE: begin
          // A deselected PROG pulse is dropped whole: its rise is seen in IDLE.
          if (fall && !bus.cs_n) begin
            op_d  = op_e'(bus.p2_in[3:2]);
            sel_d = bus.p2_in[1:0];
            if (op_d == OP_READ) begin
              state_d = ST_READ;
              read_s  = 1'b1;
              p2_en_d = 1'b1;
            end else begin
              state_d = ST_MODIFY;
            end
          end
        end
        ST_READ: begin
          if (rise) begin
            state_d = ST_IDLE;
            p2_en_d = 1'b0;
            p2_d    = '0;
          end else begin
            p2_d = bus.port_in[{sel_q, 2'b00} +: PORT_W];
          end
        end
        ST_MODIFY: begin
          if (rise) begin
            apply_s = 1'b1;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge res_i) begin
    if (!res_i) begin
      prog_q  <= 1'b1;
      state_q <= ST_IDLE;
      op_q    <= OP_READ;
      sel_q   <= '0;
      p2_q    <= '0;
      p2_en_q <= 1'b0;
    end else begin
      if (en_clk_i) prog_q <= bus.prog_n;
      state_q <= state_d;
      op_q    <= op_d;
      sel_q   <= sel_d;
      p2_q    <= p2_d;
      p2_en_q <= p2_en_d;
    end
  end

  // sel_d equals sel_q except on the decode cycle, where the read strobe needs the new port.
  for (genvar n = 0; n < N_PORTS; n++) begin : g_port
    t48_io_exp_port #(
      .RESET_VAL(PORT_RESET_VAL)
    ) u_port (
      .clk_i  (clk_i),
      .res_i  (res_i),
      .sel_i  (sel_d == n[1:0]),
      .op_i   (op_q),
      .apply_i(apply_s),
      .read_i (read_s),
      .data_i (bus.p2_in),
      .latch_o(latch_w[n]),
      .en_o   (en_w[n])
    );
  end

  assign bus.port_out = latch_w;
  assign bus.port_en  = en_w;
  assign bus.p2_out   = p2_q;
  assign bus.p2_en    = p2_en_q;

endmodule
